// File: rtl/upduino_led_pkg.sv
// Shared types and constants for the LED PWM datapath tail.
// Used by pwm_led_driver and pwm_compare.
package upduino_led_pkg;

  localparam int unsigned PWM_MAX  = 255;
  localparam int unsigned PWM_LAST = 254;

  typedef logic [7:0] duty_t;

  typedef enum logic [0:0] {
    LATCH_IDLE,
    LATCH_PEND
  } latch_state_t;

  // Channel-index width, never zero so a single-channel build still has a port.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Phase offset that spreads the channels evenly across one PWM period.
  function automatic logic [7:0] chan_offset(input int unsigned ch, input int unsigned n);
    return 8'((ch * (PWM_MAX / n)) % PWM_MAX);
  endfunction

endpackage

// File: rtl/pwm_led_driver_if.sv
// Write and latch handshake between the gamma LUT side and pwm_led_driver.
// master = producer of duty writes and latch requests, slave = the driver.
interface pwm_led_driver_if
  import upduino_led_pkg::*;
#(
  parameter int unsigned CHANNELS = 3
);

  localparam int unsigned ChanW = chan_w(CHANNELS);

  logic             wr_valid;
  logic             wr_ready;
  logic [ChanW-1:0] wr_chan;
  duty_t            wr_data;
  logic             latch_req;
  logic             latch_busy;

  modport master (
    output wr_valid,
    output wr_chan,
    output wr_data,
    output latch_req,
    input  wr_ready,
    input  latch_busy
  );

  modport slave (
    input  wr_valid,
    input  wr_chan,
    input  wr_data,
    input  latch_req,
    output wr_ready,
    output latch_busy
  );

endinterface

// File: rtl/pwm_compare.sv
// Per-channel PWM comparator with a registered output.
// With PWM_PHASE_STAGGER_EN defined the counter is rotated by a per-channel offset.
module pwm_compare
  import upduino_led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pwm_cnt_i,
  input  logic [7:0] offset_i,
  input  duty_t      duty_i,
  output logic       pwm_o
);

  logic [7:0] phase;
  logic       pwm_d;
  logic       pwm_q;

`ifdef PWM_PHASE_STAGGER_EN
  logic [8:0] phase_sum;

  // Counter runs 0..254, so the rotated phase wraps modulo 255, not 256.
  always_comb begin
    phase_sum = {1'b0, pwm_cnt_i} + {1'b0, offset_i};
    if (phase_sum >= 9'(PWM_MAX)) begin
      phase_sum = phase_sum - 9'(PWM_MAX);
    end
    phase = phase_sum[7:0];
  end
`else
  logic unused_offset;
  assign unused_offset = ^offset_i;
  assign phase         = pwm_cnt_i;
`endif

  always_comb begin
    pwm_d = (phase < duty_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_led_driver.sv
// Multi-channel PWM LED driver with double-buffered duty banks committed at period boundaries.
// Optional build macro: PWM_PHASE_STAGGER_EN (staggers channel phases inside pwm_compare).
module pwm_led_driver
  import upduino_led_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_led_driver_if.slave     bus,
  output logic                period_start,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam int unsigned ChanW = chan_w(CHANNELS);
  localparam int unsigned TickW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(PRESCALE - 1);

  logic [TickW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [7:0]                 pwm_cnt_q, pwm_cnt_d;
  duty_t [CHANNELS-1:0]       staging_q, staging_d;
  duty_t [CHANNELS-1:0]       active_q, active_d;
  latch_state_t               state_q, state_d;
  logic                       ready_q, ready_d;
  logic                       period_start_q, period_start_d;
  logic                       tick, boundary, wr_fire, commit;

  // Prescaler and period counter.
  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    boundary   = tick && (pwm_cnt_q == 8'(PWM_LAST));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == 8'(PWM_LAST)) ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  // Staging writes; an index with no matching channel is accepted and dropped.
  always_comb begin
    wr_fire   = bus.wr_valid && bus.wr_ready;
    staging_d = staging_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (wr_fire && (bus.wr_chan == ChanW'(i))) begin
        staging_d[i] = bus.wr_data;
      end
    end
  end

  // Latch FSM: a request taken on a boundary cycle waits for the next boundary.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      LATCH_IDLE: begin
        if (bus.latch_req) begin
          state_d = LATCH_PEND;
        end
      end
      LATCH_PEND: begin
        if (boundary) begin
          state_d = LATCH_IDLE;
          commit  = 1'b1;
        end
      end
    endcase
    active_d       = commit ? staging_q : active_q;
    period_start_d = boundary;
    ready_d        = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q     <= '0;
      pwm_cnt_q      <= '0;
      staging_q      <= '0;
      active_q       <= '0;
      state_q        <= LATCH_IDLE;
      ready_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      staging_q      <= staging_d;
      active_q       <= active_d;
      state_q        <= state_d;
      ready_q        <= ready_d;
      period_start_q <= period_start_d;
    end
  end

  // Staging is frozen while a commit is pending.
  assign bus.wr_ready   = ready_q && (state_q == LATCH_IDLE);
  assign bus.latch_busy = (state_q == LATCH_PEND);
  assign period_start   = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_compare u_pwm_compare (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt_i (pwm_cnt_q),
      .offset_i  (chan_offset(i, CHANNELS)),
      .duty_i    (active_q[i]),
      .pwm_o     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_driver.sv
// Scoreboard bench for pwm_led_driver: stimulus pushes per-period expectations,
// a monitor measures each PWM period window and compares.
module tb_pwm_led_driver;

  localparam int CH       = 3;
  localparam int PRESCALE = 4;
  localparam int PLEN     = 255 * PRESCALE;
`ifdef PWM_PHASE_STAGGER_EN
  localparam bit Stagger = 1'b1;
`else
  localparam bit Stagger = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          period_start;
  logic [CH-1:0] pwm_out;

  pwm_led_driver_if #(.CHANNELS(CH)) bus ();

  pwm_led_driver #(
    .CHANNELS (CH),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0]          period;
    logic [CH-1:0][31:0]  hi;
    logic [CH-1:0][31:0]  rise;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pcount   = 0;
  int   last_act[CH];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // First window sample index where a channel rises, or -1.
  function automatic int exp_rise(input int ch, input int pd, input int d);
    int off;
    bit prev, lv;
    off  = Stagger ? ch * (255 / CH) : 0;
    prev = ((254 + off) % 255) < pd;
    for (int c = 0; c < 255; c++) begin
      lv = ((c + off) % 255) < d;
      if (lv && !prev) return c * PRESCALE;
      prev = lv;
    end
    return -1;
  endfunction

  task automatic push_exp(input int d0, input int d1, input int d2);
    exp_t e;
    int   d[CH];
    d[0] = d0; d[1] = d1; d[2] = d2;
    e.period = pcount;
    for (int ch = 0; ch < CH; ch++) begin
      e.hi[ch]     = d[ch] * PRESCALE;
      e.rise[ch]   = exp_rise(ch, last_act[ch], d[ch]);
      last_act[ch] = d[ch];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one window = one PWM period, starting the clk after period_start.
  int            hi_m[CH];
  int            rise_m[CH];
  int            nsamp;
  logic [CH-1:0] prev_out;
  bit            started, ps_prev;

  initial begin
    exp_t e;
    int   closing;
    started = 0; ps_prev = 0; nsamp = 0; prev_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pcount = 0; started = 0; ps_prev = 0; nsamp = 0; prev_out = '0;
        exp_q.delete();
      end else begin
        if (ps_prev) begin
          closing = pcount - 1;
          if (started) begin
            if (exp_q.size() > 0 && int'(exp_q[0].period) < closing) begin
              e = exp_q.pop_front();
              chk("sb_stale_expectation", int'(e.period), closing);
            end
            if (exp_q.size() > 0 && int'(exp_q[0].period) == closing) begin
              e = exp_q.pop_front();
              chk($sformatf("p%0d_len", closing), nsamp, PLEN);
              for (int ch = 0; ch < CH; ch++) begin
                chk($sformatf("p%0d_ch%0d_high_clks", closing, ch), hi_m[ch], int'(e.hi[ch]));
                chk($sformatf("p%0d_ch%0d_rise", closing, ch), rise_m[ch], int'(e.rise[ch]));
              end
            end
          end
          started = 1; nsamp = 0;
          for (int ch = 0; ch < CH; ch++) begin
            hi_m[ch] = 0; rise_m[ch] = -1;
          end
        end
        for (int ch = 0; ch < CH; ch++) begin
          if (pwm_out[ch]) hi_m[ch]++;
          if (pwm_out[ch] && !prev_out[ch] && rise_m[ch] < 0) rise_m[ch] = nsamp;
        end
        prev_out = pwm_out;
        nsamp++;
        if (period_start) pcount++;
        ps_prev = period_start;
      end
    end
  end

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * PLEN);
    if (!period_start) begin
      n_checks++; n_fail++;
      $display("FAIL wait_period_start: got timeout after %0d clks, expected a pulse", n);
    end
    #1;
  endtask

  task automatic do_write(input int ch, input int data);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_chan  = ch[1:0];
    bus.wr_data  = data[7:0];
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_latch();
    @(negedge clk);
    bus.latch_req = 1'b1;
    @(negedge clk);
    bus.latch_req = 1'b0;
  endtask

  task automatic do_reset_release();
    int n;
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_ready_after_reset", int'(bus.wr_ready), 1);
    chk("latch_busy_after_reset", int'(bus.latch_busy), 0);
    wait_ps(n);
    chk("first_period_start_clks", n, PLEN - 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_chan = '0; bus.wr_data = '0; bus.latch_req = 1'b0;
    for (int ch = 0; ch < CH; ch++) last_act[ch] = 0;

    // 1: reset state, then two idle periods
    #1;
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_wr_ready", int'(bus.wr_ready), 0);
    chk("reset_latch_busy", int'(bus.latch_busy), 0);
    chk("reset_period_start", int'(period_start), 0);
    repeat (3) @(negedge clk);
    do_reset_release();
    push_exp(0, 0, 0);
    wait_ps(n);
    push_exp(0, 0, 0);

    // 2: duties 0/128/255 committed at the next boundary
    do_write(0, 0);
    do_write(1, 128);
    do_write(2, 255);
    do_latch();
    chk("t2_latch_busy", int'(bus.latch_busy), 1);
    wait_ps(n);
    push_exp(0, 128, 255);
    chk("t2_busy_cleared", int'(bus.latch_busy), 0);
    wait_ps(n);
    push_exp(0, 128, 255);

    // 3: latch at pwm_cnt=10, writes blocked until commit
    repeat (37) @(negedge clk);
    do_write(1, 64);
    do_latch();
    chk("t3_latch_busy", int'(bus.latch_busy), 1);
    chk("t3_wr_ready_low", int'(bus.wr_ready), 0);
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_chan = 2'd0; bus.wr_data = 8'd200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_wr_ready_blocked", int'(bus.wr_ready), 0);
    end
    bus.wr_valid = 1'b0;
    wait_ps(n);
    push_exp(0, 64, 255);
    chk("t3_busy_cleared", int'(bus.latch_busy), 0);
    chk("t3_wr_ready_back", int'(bus.wr_ready), 1);
    do_latch();
    wait_ps(n);
    push_exp(0, 64, 255);

    // 4: latch and write on the boundary cycle; commit one period later
    repeat (PLEN - 1) @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_chan = 2'd2; bus.wr_data = 8'd180;
    bus.latch_req = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.latch_req = 1'b0;
    chk("t4_boundary_aligned", int'(period_start), 1);
    chk("t4_still_pending", int'(bus.latch_busy), 1);
    #1;
    push_exp(0, 64, 255);
    wait_ps(n);
    push_exp(0, 64, 180);
    chk("t4_busy_cleared", int'(bus.latch_busy), 0);

    // 5: out-of-range channel write is discarded
    do_write(3, 50);
    do_latch();
    wait_ps(n);
    push_exp(0, 64, 180);

    // 6: reset at pwm_cnt=100 with a latch pending
    do_write(0, 77);
    do_latch();
    repeat (396) @(negedge clk);
    chk("t6_busy_before_reset", int'(bus.latch_busy), 1);
    chk("t6_pwm_before_reset", int'(pwm_out), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_pwm_async_clear", int'(pwm_out), 0);
    chk("t6_busy_async_clear", int'(bus.latch_busy), 0);
    chk("t6_wr_ready_in_reset", int'(bus.wr_ready), 0);
    for (int ch = 0; ch < CH; ch++) last_act[ch] = 0;
    repeat (3) @(negedge clk);
    do_reset_release();
    push_exp(0, 0, 0);
    do_latch();
    wait_ps(n);
    push_exp(0, 0, 0);

    // 7: duty 85 on every channel (rise points depend on stagger build)
    do_write(0, 85);
    do_write(1, 85);
    do_write(2, 85);
    do_latch();
    wait_ps(n);
    push_exp(85, 85, 85);
    wait_ps(n);
    push_exp(85, 85, 85);

    wait_ps(n);
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
